// File: rtl/mat2x2_alu_seq_if.sv
// Handshake bundle for mat2x2_alu_seq: operand/op request channel and
// 2x2 result channel. Parameter W is the operand element width; result
// elements are 2W+1 bits.
interface mat2x2_alu_seq_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   a00, a01, a10, a11;
  logic [W-1:0]   b00, b01, b10, b11;
  logic           out_valid;
  logic           out_ready;
  logic [2*W:0]   y00, y01, y10, y11;
  logic           err;

  modport master (
    output in_valid, op, a00, a01, a10, a11, b00, b01, b10, b11, out_ready,
    input  in_ready, out_valid, y00, y01, y10, y11, err
  );

  modport slave (
    input  in_valid, op, a00, a01, a10, a11, b00, b01, b10, b11, out_ready,
    output in_ready, out_valid, y00, y01, y10, y11, err
  );
endinterface

// File: rtl/mat2x2_alu_seq.sv
// Sequential 2x2 matrix ALU: ADD, SUB, matrix product (MUL) and
// element-wise product (HAD) on W-bit elements, 2W+1-bit results.
// A single multiplier is time-shared across the HAD/MUL steps.
// Optional feature: define MAT_ALU_TRANSPOSE_EN to enable op 100 (TRN,
// transpose of A); otherwise op 100 is reported as illegal.
module mat2x2_alu_seq #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  mat2x2_alu_seq_if.slave bus
);

  localparam int YW = 2 * W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_HAD = 3'b011,
    OP_TRN = 3'b100
  } op_t;

  state_t          state;
  logic [2:0]      cnt;
  logic [2:0]      op_r;
  logic [W-1:0]    a_r [4];
  logic [W-1:0]    b_r [4];
  logic [YW-1:0]   y_r [4];
  logic            ov_r;
  logic            err_r;

  logic [1:0]      ai, bi, tgt;
  logic [YW-1:0]   ma, mb, prod;
  logic            last;

  // Zero- or sign-extend an element to result width.
  function automatic logic [YW-1:0] ext(input logic [W-1:0] v);
    return {{(W + 1){v[W-1] & SIGNED}}, v};
  endfunction

  // Operand selection for the shared multiplier and step bookkeeping.
  // Arrays are indexed 2*row+col. For MUL, step cnt = {i, k, j} picks
  // a[i][j] * b[j][k] and accumulates into y[i][k].
  always_comb begin
    ai   = cnt[1:0];
    bi   = cnt[1:0];
    tgt  = cnt[1:0];
    last = 1'b1;
    if (op_r == OP_MUL) begin
      ai   = {cnt[2], cnt[0]};
      bi   = {cnt[0], cnt[1]};
      tgt  = cnt[2:1];
      last = (cnt == 3'd7);
    end else if (op_r == OP_HAD) begin
      last = (cnt == 3'd3);
    end
    // Low 2W+1 bits of the product are exact for both signednesses,
    // since every legal result fits in 2W+1 bits.
    ma   = ext(a_r[ai]);
    mb   = ext(b_r[bi]);
    prod = ma * mb;
  end

  // Control FSM, operand latches and result accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_r  <= '0;
      ov_r  <= 1'b0;
      err_r <= 1'b0;
      a_r   <= '{default: '0};
      b_r   <= '{default: '0};
      y_r   <= '{default: '0};
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_r   <= bus.op;
            a_r[0] <= bus.a00;
            a_r[1] <= bus.a01;
            a_r[2] <= bus.a10;
            a_r[3] <= bus.a11;
            b_r[0] <= bus.b00;
            b_r[1] <= bus.b01;
            b_r[2] <= bus.b10;
            b_r[3] <= bus.b11;
            y_r    <= '{default: '0};
            cnt    <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          case (op_r)
            OP_ADD: begin
              y_r[0] <= ext(a_r[0]) + ext(b_r[0]);
              y_r[1] <= ext(a_r[1]) + ext(b_r[1]);
              y_r[2] <= ext(a_r[2]) + ext(b_r[2]);
              y_r[3] <= ext(a_r[3]) + ext(b_r[3]);
            end
            OP_SUB: begin
              y_r[0] <= ext(a_r[0]) - ext(b_r[0]);
              y_r[1] <= ext(a_r[1]) - ext(b_r[1]);
              y_r[2] <= ext(a_r[2]) - ext(b_r[2]);
              y_r[3] <= ext(a_r[3]) - ext(b_r[3]);
            end
            OP_MUL: y_r[tgt] <= y_r[tgt] + prod;
            OP_HAD: y_r[tgt] <= prod;
`ifdef MAT_ALU_TRANSPOSE_EN
            OP_TRN: begin
              y_r[0] <= ext(a_r[0]);
              y_r[1] <= ext(a_r[2]);
              y_r[2] <= ext(a_r[1]);
              y_r[3] <= ext(a_r[3]);
            end
`endif
            // Illegal op: results stay at the zeros loaded on accept.
            default: err_r <= 1'b1;
          endcase
          cnt <= cnt + 3'd1;
          if (last) begin
            state <= S_DONE;
            ov_r  <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            ov_r  <= 1'b0;
            err_r <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = ov_r;
  assign bus.err       = err_r;
  assign bus.y00       = y_r[0];
  assign bus.y01       = y_r[1];
  assign bus.y10       = y_r[2];
  assign bus.y11       = y_r[3];

endmodule
